// File: rtl/regfile_dump_reader_if.sv
// Beat stream carrying {address, data, last} from the dump reader to its consumer.
// A beat transfers on any clock edge where out_valid and out_ready are both high.
interface regfile_dump_reader_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_addr;
  logic [DATA_W-1:0] out_data;
  logic              out_last;

  modport master (
    output out_valid,
    output out_addr,
    output out_data,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_addr,
    input  out_data,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/regfile_dump_reader.sv
// Register-file dump reader: walks an inclusive, wrapping address range and
// streams one {address, data} beat per register over a valid/ready port.
module regfile_dump_reader #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_W-1:0]     first_addr,
  input  logic [ADDR_W-1:0]     last_addr,
  output logic [ADDR_W-1:0]     rf_read_address,
  input  logic [DATA_W-1:0]     rf_read_data,
  output logic                  busy,
  output logic                  done,
  regfile_dump_reader_if.master stream
);
  // state | meaning
  // IDLE  | waiting for start
  // READ  | rf_read_address = cur; word captured on the edge
  // HOLD  | beat presented, waiting for out_ready
  // DONE  | one-cycle done pulse, then back to IDLE

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_HOLD = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] cur;
  logic [ADDR_W-1:0] end_addr;

  assign rf_read_address = cur;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state            <= S_IDLE;
      cur              <= '0;
      end_addr         <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      stream.out_valid <= 1'b0;
      stream.out_addr  <= '0;
      stream.out_data  <= '0;
      stream.out_last  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && !abort) begin
            cur      <= first_addr;
            end_addr <= last_addr;
            busy     <= 1'b1;
            state    <= S_READ;
          end
        end
        S_READ: begin
          stream.out_data  <= rf_read_data;
          stream.out_addr  <= cur;
          stream.out_last  <= (cur == end_addr);
          stream.out_valid <= 1'b1;
          state            <= S_HOLD;
        end
        S_HOLD: begin
          if (stream.out_valid && stream.out_ready) begin
            stream.out_valid <= 1'b0;
            if (stream.out_last) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              cur   <= cur + ADDR_W'(1);
              state <= S_READ;
            end
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      // Abort overrides whatever the state case decided, including a pending handshake.
      if (abort && state != S_IDLE) begin
        state            <= S_IDLE;
        busy             <= 1'b0;
        done             <= 1'b0;
        stream.out_valid <= 1'b0;
        stream.out_last  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_regfile_dump_reader.sv
// Bench for regfile_dump_reader: a queue of expected addresses plus a register
// file array predict every beat; one negedge process compares the stream.
module tb_regfile_dump_reader;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int N  = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [AW-1:0] first_addr = '0;
  logic [AW-1:0] last_addr = '0;
  logic [AW-1:0] rf_read_address;
  logic [DW-1:0] rf_read_data;
  logic          busy;
  logic          done;
  logic [DW-1:0] mem [N];

  regfile_dump_reader_if #(.ADDR_W(AW), .DATA_W(DW)) sif ();

  regfile_dump_reader #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .abort           (abort),
    .first_addr      (first_addr),
    .last_addr       (last_addr),
    .rf_read_address (rf_read_address),
    .rf_read_data    (rf_read_data),
    .busy            (busy),
    .done            (done),
    .stream          (sif)
  );

  always #5 clk = ~clk;

  // Behavioural register file with a combinational read port.
  assign rf_read_data = mem[rf_read_address];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model state
  logic [AW-1:0] exp_q [$];
  logic [AW-1:0] log_addr [$];
  logic [DW-1:0] log_data [$];
  logic          log_last [$];
  bit            have_beat = 0;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_data;
  bit            b_last;
  bit            dump_active = 0;
  int            done_count = 0;
  bit            prev_hs = 0;
  bit            prev_done = 0;
  int            ready_mode = 1;  // 0: ready low, 1: ready high, 2: random, 3: manual

  initial begin
    sif.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: sif.out_ready = 1'b0;
        1: sif.out_ready = 1'b1;
        2: sif.out_ready = 1'($urandom_range(0, 1));
        default: ;
      endcase
    end
  end

  // Compare process
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        exp_q.delete();
        have_beat   = 0;
        dump_active = 0;
        prev_hs     = 0;
        prev_done   = 0;
      end else begin
        if (prev_hs) chk("gap_after_beat", sif.out_valid, 0);
        prev_hs = 0;
        if (sif.out_valid) begin
          if (!have_beat) begin
            chk("beat_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
              b_addr    = exp_q[0];
              b_data    = mem[b_addr];
              b_last    = (exp_q.size() == 1);
              have_beat = 1;
            end
          end
          if (have_beat) begin
            chk("beat_addr", sif.out_addr, b_addr);
            chk("beat_data", sif.out_data, b_data);
            chk("beat_last", sif.out_last, b_last);
            if (sif.out_ready && !abort) begin
              log_addr.push_back(sif.out_addr);
              log_data.push_back(sif.out_data);
              log_last.push_back(sif.out_last);
              void'(exp_q.pop_front());
              have_beat = 0;
              prev_hs   = 1;
            end
          end
        end else if (have_beat) begin
          chk("valid_held", sif.out_valid, 1);
        end
        if (abort && busy) begin
          exp_q.delete();
          have_beat   = 0;
          dump_active = 0;
          prev_hs     = 0;
        end
        if (done) begin
          chk("done_expected", dump_active, 1);
          chk("done_queue_empty", exp_q.size(), 0);
          chk("done_single", prev_done, 0);
          done_count++;
          dump_active = 0;
        end
        prev_done = done;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [AW-1:0] f, input logic [AW-1:0] l);
    int beats;
    beats = int'((l - f) & 5'h1f) + 1;
    exp_q.delete();
    log_addr.delete();
    log_data.delete();
    log_last.delete();
    for (int i = 0; i < beats; i++) exp_q.push_back(AW'(f + AW'(i)));
    dump_active = 1;
    first_addr  = f;
    last_addr   = l;
    start       = 1'b1;
    step();
    start       = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int dc0;
    int k;
    dc0 = done_count;
    k   = 0;
    while (done_count == dc0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("done_within_budget", done_count != dc0, 1);
    @(posedge clk);
    @(negedge clk);
    chk("idle_after_done", busy, 0);
  endtask

  task automatic wait_valid(input int budget);
    int k;
    k = 0;
    @(negedge clk);
    while (!sif.out_valid && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("valid_within_budget", sif.out_valid, 1);
  endtask

  initial begin
    int dc;
    logic [AW-1:0] f;
    logic [AW-1:0] l;
    for (int i = 0; i < N; i++) mem[i] = $urandom;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", sif.out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rf_addr", rf_read_address, 0);
    chk("rst_out_addr", sif.out_addr, 0);
    chk("rst_out_data", sif.out_data, 0);
    chk("rst_out_last", sif.out_last, 0);
    step();
    rst = 1'b1;

    // Basic 3-beat dump with latency check
    mem[3] = 32'hAAAA_0003;
    mem[4] = 32'hBBBB_0004;
    mem[5] = 32'hCCCC_0005;
    ready_mode = 1;
    launch(5'd3, 5'd5);
    @(negedge clk);
    chk("lat_valid_n1", sif.out_valid, 0);
    chk("lat_busy_n1", busy, 1);
    @(negedge clk);
    chk("lat_valid_n2", sif.out_valid, 1);
    wait_done(200);
    chk("t1_beats", log_addr.size(), 3);
    if (log_addr.size() == 3) begin
      chk("t1_a0", log_addr[0], 3);
      chk("t1_d0", log_data[0], 32'hAAAA_0003);
      chk("t1_d1", log_data[1], 32'hBBBB_0004);
      chk("t1_a2", log_addr[2], 5);
      chk("t1_d2", log_data[2], 32'hCCCC_0005);
      chk("t1_last2", log_last[2], 1);
      chk("t1_last1", log_last[1], 0);
    end

    // Wrapping range 30..1
    ready_mode = 2;
    launch(5'd30, 5'd1);
    wait_done(400);
    chk("t2_beats", log_addr.size(), 4);
    if (log_addr.size() == 4) begin
      chk("t2_a0", log_addr[0], 30);
      chk("t2_a1", log_addr[1], 31);
      chk("t2_a2", log_addr[2], 0);
      chk("t2_a3", log_addr[3], 1);
      chk("t2_last0", log_last[0], 0);
      chk("t2_last3", log_last[3], 1);
    end

    // Full 32-register walk 7..6
    launch(5'd7, 5'd6);
    wait_done(2000);
    chk("t3_beats", log_addr.size(), 32);
    if (log_addr.size() == 32) begin
      chk("t3_a0", log_addr[0], 7);
      chk("t3_a24", log_addr[24], 31);
      chk("t3_a25", log_addr[25], 0);
      chk("t3_a31", log_addr[31], 6);
      chk("t3_last30", log_last[30], 0);
      chk("t3_last31", log_last[31], 1);
    end

    // Stall in HOLD while the sampled register is rewritten
    ready_mode = 0;
    mem[10] = 32'h1111_0010;
    mem[11] = 32'h2222_0011;
    launch(5'd10, 5'd11);
    wait_valid(50);
    for (int i = 0; i < 5; i++) begin
      step();
      mem[10] = $urandom;
      @(negedge clk);
      chk("t4_hold_valid", sif.out_valid, 1);
      chk("t4_hold_addr", sif.out_addr, 10);
      chk("t4_hold_data", sif.out_data, 32'h1111_0010);
    end
    ready_mode = 1;
    wait_done(200);
    chk("t4_beats", log_addr.size(), 2);
    if (log_data.size() == 2) chk("t4_d0", log_data[0], 32'h1111_0010);

    // Abort during HOLD of the second beat
    ready_mode = 3;
    step();
    sif.out_ready = 1'b0;
    launch(5'd0, 5'd3);
    wait_valid(50);
    step();
    sif.out_ready = 1'b1;
    step();
    sif.out_ready = 1'b0;
    wait_valid(50);
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    @(negedge clk);
    chk("t5_valid_after_abort", sif.out_valid, 0);
    chk("t5_busy_after_abort", busy, 0);
    chk("t5_last_after_abort", sif.out_last, 0);
    dc = done_count;
    repeat (10) @(negedge clk);
    chk("t5_no_done", done_count, dc);
    ready_mode = 1;
    step();
    launch(5'd20, 5'd22);
    wait_done(200);
    chk("t5_beats_after", log_addr.size(), 3);

    // Start while busy is ignored
    ready_mode = 2;
    launch(5'd5, 5'd9);
    repeat (3) step();
    first_addr = 5'd20;
    last_addr  = 5'd25;
    start      = 1'b1;
    step();
    start      = 1'b0;
    wait_done(400);
    chk("t6_beats", log_addr.size(), 5);
    if (log_addr.size() == 5) chk("t6_a4", log_addr[4], 9);

    // Reset mid-dump
    ready_mode = 1;
    launch(5'd0, 5'd31);
    repeat (10) step();
    rst = 1'b0;
    step();
    step();
    @(negedge clk);
    chk("t6_rst_valid", sif.out_valid, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_rf_addr", rf_read_address, 0);
    chk("t6_rst_out_data", sif.out_data, 0);
    chk("t6_rst_out_addr", sif.out_addr, 0);
    dc = done_count;
    step();
    rst = 1'b1;
    repeat (5) @(negedge clk);
    chk("t6_no_done_after_rst", done_count, dc);

    // Randomized dumps
    for (int r = 0; r < 12; r++) begin
      step();
      for (int i = 0; i < N; i++) mem[i] = $urandom;
      f = AW'($urandom_range(0, N - 1));
      l = AW'($urandom_range(0, N - 1));
      ready_mode = int'($urandom_range(1, 2));
      launch(f, l);
      wait_done(2000);
      chk("rand_beats", log_addr.size(), int'((l - f) & 5'h1f) + 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
